// File: rtl/fifo_sample_packer.sv
// Serialises one filtered X/Y/Z set into three ADXL355-format FIFO entries and flags overflow.
// Optional FIFO_DROP_CNT_EN adds a saturating 8-bit count of dropped sets (drop_cnt).
module fifo_sample_packer #(
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 1 << ADDR_WIDTH,
  localparam int SET_SIZE  = 3
) (
  input  logic                  mems_clk,
  input  logic                  rst_n,
  input  logic                  sample_valid,
  input  logic [19:0]           xdata_in,
  input  logic [19:0]           ydata_in,
  input  logic [19:0]           zdata_in,
  input  logic                  STANDBY,
  input  logic [ADDR_WIDTH:0]   fifo_sample_num,
  input  logic                  ovr_clr,
  output logic                  wr_en,
  output logic [23:0]           filter_fifo_data,
  output logic                  FIFO_OVR,
  output logic                  busy,
`ifdef FIFO_DROP_CNT_EN
  output logic [7:0]            drop_cnt,
`endif
  output logic [2:0]            fsm_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WR_X   = 3'd1,
    WR_Y   = 3'd2,
    WR_Z   = 3'd3,
    SETTLE = 3'd4
  } state_t;

  // Highest occupancy that still leaves room for a whole set; anything above,
  // including the illegal values beyond DEPTH, counts as full.
  localparam logic [ADDR_WIDTH:0] MAX_OCC = (ADDR_WIDTH+1)'(DEPTH - SET_SIZE);

  state_t      state, next_state;
  logic [19:0] y_lat, z_lat;
  logic        space_ok;
  logic        accept;
  logic        drop;

  function automatic logic [23:0] fmt(input logic [19:0] d, input logic first);
    fmt = {d, 3'b000, first};
  endfunction

  assign space_ok  = (fifo_sample_num <= MAX_OCC);
  assign busy      = (state != IDLE);
  assign fsm_state = state;

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    drop       = 1'b0;
    unique case (state)
      IDLE: begin
        if (sample_valid && !STANDBY) begin
          if (space_ok) begin
            accept     = 1'b1;
            next_state = WR_X;
          end else begin
            drop = 1'b1;
          end
        end
      end
      WR_X:    next_state = WR_Y;
      WR_Y:    next_state = WR_Z;
      WR_Z:    next_state = SETTLE;
      SETTLE:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
    // A new set arriving mid-serialisation is lost; the current set carries on.
    if (state != IDLE && sample_valid && !STANDBY) drop = 1'b1;
  end

  always_ff @(posedge mems_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge mems_clk or negedge rst_n) begin
    if (!rst_n) begin
      y_lat <= '0;
      z_lat <= '0;
    end else if (accept) begin
      y_lat <= ydata_in;
      z_lat <= zdata_in;
    end
  end

  // Write port is registered from next_state so each entry appears exactly
  // while the FSM sits in the matching WR_* state; data holds otherwise.
  always_ff @(posedge mems_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en            <= 1'b0;
      filter_fifo_data <= '0;
    end else begin
      wr_en <= 1'b0;
      unique case (next_state)
        WR_X: begin
          wr_en            <= 1'b1;
          filter_fifo_data <= fmt(xdata_in, 1'b1);
        end
        WR_Y: begin
          wr_en            <= 1'b1;
          filter_fifo_data <= fmt(y_lat, 1'b0);
        end
        WR_Z: begin
          wr_en            <= 1'b1;
          filter_fifo_data <= fmt(z_lat, 1'b0);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge mems_clk or negedge rst_n) begin
    if (!rst_n) begin
      FIFO_OVR <= 1'b0;
    end else if (drop) begin
      FIFO_OVR <= 1'b1;
    end else if (ovr_clr) begin
      FIFO_OVR <= 1'b0;
    end
  end

`ifdef FIFO_DROP_CNT_EN
  always_ff @(posedge mems_clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (ovr_clr) begin
      drop_cnt <= drop ? 8'd1 : 8'd0;
    end else if (drop && drop_cnt != 8'hFF) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_sample_packer.sv
// Directed bench for fifo_sample_packer: vector table of whole sets plus corner-case sequences.
module tb_fifo_sample_packer;

  logic        mems_clk;
  logic        rst_n;
  logic        sample_valid;
  logic [19:0] xdata_in, ydata_in, zdata_in;
  logic        STANDBY;
  logic [4:0]  fifo_sample_num;
  logic        ovr_clr;
  logic        wr_en;
  logic [23:0] filter_fifo_data;
  logic        FIFO_OVR;
  logic        busy;
  logic [2:0]  fsm_state;
`ifdef FIFO_DROP_CNT_EN
  logic [7:0]  drop_cnt;
`endif

  int checks = 0;
  int errors = 0;

  fifo_sample_packer #(.ADDR_WIDTH(4)) dut (
    .mems_clk        (mems_clk),
    .rst_n           (rst_n),
    .sample_valid    (sample_valid),
    .xdata_in        (xdata_in),
    .ydata_in        (ydata_in),
    .zdata_in        (zdata_in),
    .STANDBY         (STANDBY),
    .fifo_sample_num (fifo_sample_num),
    .ovr_clr         (ovr_clr),
    .wr_en           (wr_en),
    .filter_fifo_data(filter_fifo_data),
    .FIFO_OVR        (FIFO_OVR),
    .busy            (busy),
`ifdef FIFO_DROP_CNT_EN
    .drop_cnt        (drop_cnt),
`endif
    .fsm_state       (fsm_state)
  );

  // clock / reset
  initial mems_clk = 1'b0;
  always #5 mems_clk = ~mems_clk;

  typedef struct {
    logic [4:0]  num;
    logic [19:0] x, y, z;
    logic        acc;
    logic [23:0] ex, ey, ez;
  } vec_t;

  vec_t vecs[7];

  task automatic tick();
    @(posedge mems_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse_clr();
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    check("ovr_cleared", FIFO_OVR, 0);
  endtask

  task automatic drive_set(input logic [19:0] x, input logic [19:0] y, input logic [19:0] z);
    xdata_in     = x;
    ydata_in     = y;
    zdata_in     = z;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    xdata_in     = '0;
    ydata_in     = '0;
    zdata_in     = '0;
  endtask

  logic [23:0] last_data;
  int          entries;
  int          occ;
  int          seen_x;

  initial begin
    rst_n           = 1'b0;
    sample_valid    = 1'b0;
    xdata_in        = '0;
    ydata_in        = '0;
    zdata_in        = '0;
    STANDBY         = 1'b0;
    fifo_sample_num = '0;
    ovr_clr         = 1'b0;

    vecs[0] = '{5'd0,  20'h12345, 20'hABCDE, 20'h00001, 1'b1, 24'h123451, 24'hABCDE0, 24'h000010};
    vecs[1] = '{5'd13, 20'h00000, 20'hFFFFF, 20'h5A5A5, 1'b1, 24'h000001, 24'hFFFFF0, 24'h5A5A50};
    vecs[2] = '{5'd14, 20'h11111, 20'h22222, 20'h33333, 1'b0, 24'h0,      24'h0,      24'h0};
    vecs[3] = '{5'd16, 20'h44444, 20'h55555, 20'h66666, 1'b0, 24'h0,      24'h0,      24'h0};
    vecs[4] = '{5'd17, 20'h77777, 20'h88888, 20'h99999, 1'b0, 24'h0,      24'h0,      24'h0};
    vecs[5] = '{5'd31, 20'hAAAAA, 20'hBBBBB, 20'hCCCCC, 1'b0, 24'h0,      24'h0,      24'h0};
    vecs[6] = '{5'd5,  20'hFFFFF, 20'h80000, 20'h7FFFF, 1'b1, 24'hFFFFF1, 24'h800000, 24'h7FFFF0};

    tick();
    tick();
    check("rst_wr_en", wr_en, 0);
    check("rst_data", filter_fifo_data, 0);
    check("rst_ovr", FIFO_OVR, 0);
    check("rst_busy", busy, 0);
    check("rst_state", fsm_state, 0);
`ifdef FIFO_DROP_CNT_EN
    check("rst_drop_cnt", drop_cnt, 0);
`endif
    rst_n = 1'b1;
    tick();

    // table of whole sets at various occupancies
    last_data = 24'h0;
    for (int i = 0; i < 7; i++) begin
      fifo_sample_num = vecs[i].num;
      drive_set(vecs[i].x, vecs[i].y, vecs[i].z);
      if (vecs[i].acc) begin
        check($sformatf("v%0d_x_en", i), wr_en, 1);
        check($sformatf("v%0d_x", i), filter_fifo_data, vecs[i].ex);
        check($sformatf("v%0d_busy", i), busy, 1);
        tick();
        check($sformatf("v%0d_y_en", i), wr_en, 1);
        check($sformatf("v%0d_y", i), filter_fifo_data, vecs[i].ey);
        tick();
        check($sformatf("v%0d_z_en", i), wr_en, 1);
        check($sformatf("v%0d_z", i), filter_fifo_data, vecs[i].ez);
        tick();
        check($sformatf("v%0d_settle_en", i), wr_en, 0);
        check($sformatf("v%0d_settle_busy", i), busy, 1);
        check($sformatf("v%0d_hold", i), filter_fifo_data, vecs[i].ez);
        tick();
        check($sformatf("v%0d_idle_busy", i), busy, 0);
        check($sformatf("v%0d_ovr", i), FIFO_OVR, 0);
        last_data = vecs[i].ez;
      end else begin
        for (int c = 0; c < 4; c++) begin
          check($sformatf("v%0d_no_wr", i), wr_en, 0);
          check($sformatf("v%0d_idle", i), busy, 0);
          if (c < 3) tick();
        end
        check($sformatf("v%0d_ovr", i), FIFO_OVR, 1);
        check($sformatf("v%0d_hold", i), filter_fifo_data, last_data);
        pulse_clr();
      end
    end
    fifo_sample_num = '0;

    // drop coinciding with ovr_clr: set wins
    fifo_sample_num = 5'd16;
    ovr_clr         = 1'b1;
    drive_set(20'h1, 20'h2, 20'h3);
    ovr_clr         = 1'b0;
    check("clr_vs_drop_ovr", FIFO_OVR, 1);
`ifdef FIFO_DROP_CNT_EN
    check("clr_vs_drop_cnt", drop_cnt, 1);
`endif
    pulse_clr();
    fifo_sample_num = '0;

    // second set two cycles after the first, while busy
    drive_set(20'h0A0A0, 20'h0B0B0, 20'h0C0C0);
    check("b2b_x", filter_fifo_data, 24'h0A0A01);
    tick();
    check("b2b_y", filter_fifo_data, 24'h0B0B00);
    drive_set(20'hDEAD0, 20'hBEEF0, 20'hCAFE0);
    check("b2b_z_en", wr_en, 1);
    check("b2b_z", filter_fifo_data, 24'h0C0C00);
    check("b2b_ovr", FIFO_OVR, 1);
`ifdef FIFO_DROP_CNT_EN
    check("b2b_drop_cnt", drop_cnt, 1);
`endif
    tick();
    check("b2b_settle", wr_en, 0);
    tick();
    check("b2b_idle", busy, 0);
    check("b2b_no_second", wr_en, 0);
    pulse_clr();

    // standby ignores sample_valid
    STANDBY = 1'b1;
    for (int p = 0; p < 5; p++) begin
      drive_set(20'h13579, 20'h2468A, 20'h11111);
      check("stby_no_wr", wr_en, 0);
      tick();
      check("stby_no_wr2", wr_en, 0);
    end
    check("stby_ovr", FIFO_OVR, 0);
    STANDBY = 1'b0;

    // standby raised mid-set does not tear it
    drive_set(20'h00F00, 20'h00E00, 20'h00D00);
    check("stby_mid_x", filter_fifo_data, 24'h00F001);
    tick();
    check("stby_mid_y", filter_fifo_data, 24'h00E000);
    STANDBY = 1'b1;
    tick();
    check("stby_mid_z_en", wr_en, 1);
    check("stby_mid_z", filter_fifo_data, 24'h00D000);
    tick();
    tick();
    STANDBY = 1'b0;
    check("stby_mid_ovr", FIFO_OVR, 0);

    // asynchronous reset during WR_Y
    drive_set(20'h55555, 20'h66666, 20'h77777);
    check("rst_mid_x", filter_fifo_data, 24'h555551);
    tick();
    check("rst_mid_y_en", wr_en, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_wr_en", wr_en, 0);
    check("rst_mid_data", filter_fifo_data, 0);
    check("rst_mid_busy", busy, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("rst_mid_idle_wr", wr_en, 0);
    drive_set(20'h98765, 20'h43210, 20'h0FEDC);
    check("rst_after_x_en", wr_en, 1);
    check("rst_after_x", filter_fifo_data, 24'h987651);
    tick();
    check("rst_after_y", filter_fifo_data, 24'h432100);
    tick();
    tick();
    tick();

    // 16 sets with a reader draining one entry per cycle
    occ     = 0;
    entries = 0;
    seen_x  = 0;
    for (int cyc = 0; cyc < 90; cyc++) begin
      fifo_sample_num = 5'(occ);
      sample_valid    = ((cyc % 5) == 0) && (cyc < 80);
      xdata_in        = 20'(cyc);
      ydata_in        = 20'(cyc + 1);
      zdata_in        = 20'(cyc + 2);
      tick();
      if (occ > 0) occ--;
      if (wr_en) begin
        check("drain_bit0", filter_fifo_data[0], ((entries % 3) == 0) ? 1 : 0);
        if (filter_fifo_data[0]) seen_x++;
        entries++;
        occ++;
      end
    end
    sample_valid = 1'b0;
    check("drain_entries", entries, 48);
    check("drain_sets", seen_x, 16);
    check("drain_ovr", FIFO_OVR, 0);
    fifo_sample_num = '0;

`ifdef FIFO_DROP_CNT_EN
    fifo_sample_num = 5'd16;
    sample_valid    = 1'b1;
    for (int d = 0; d < 300; d++) tick();
    sample_valid = 1'b0;
    check("sat_drop_cnt", drop_cnt, 8'hFF);
    check("sat_ovr", FIFO_OVR, 1);
    pulse_clr();
    check("sat_cleared", drop_cnt, 0);
    fifo_sample_num = '0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_sample_packer.md
Name: fifo_sample_packer

Overview:
- Upstream stage of synchronous_fifo. Takes one filtered X/Y/Z acceleration set (20-bit per axis) per output-data-rate tick.
- Serialises the set into three 24-bit FIFO entries in ADXL355 FIFO format and drives the FIFO write port (wr_en / filter_fifo_data).
- Performs overflow detection and reports a sticky FIFO_OVR flag to register_files.

Parameters:
- ADDR_WIDTH, 4, FIFO address width; must match synchronous_fifo.
- DEPTH, 1<<ADDR_WIDTH, FIFO capacity in entries.
- SET_SIZE, 3, entries written per sample set; fixed, not for override.

Ports:
- mems_clk  in  1  block clock.
- rst_n  in  1  asynchronous active-low reset.
- sample_valid  in  1  one-cycle pulse; new X/Y/Z set present.
- xdata_in  in  20  X sample, two's complement.
- ydata_in  in  20  Y sample.
- zdata_in  in  20  Z sample.
- STANDBY  in  1  from register_files; 1 = measurement off.
- fifo_sample_num  in  ADDR_WIDTH+1  current FIFO occupancy.
- ovr_clr  in  1  one-cycle pulse from register_files; clears FIFO_OVR.
- wr_en  out  1  FIFO write strobe.
- filter_fifo_data  out  24  FIFO write data.
- FIFO_OVR  out  1  sticky overflow flag.
- busy  out  1  set in progress (state != IDLE).

Behaviour:
- Reset (async, rst_n=0): state=IDLE; wr_en=0; filter_fifo_data=0; FIFO_OVR=0; busy=0; sample latches=0. Reset mid-set abandons remaining axes. No partial set resumes after release.
- Entry format: [23:4]=axis data[19:0]; [3:2]=2'b00; [1]=0 (empty indicator, owned by reader side); [0]=1 for X entry, 0 for Y/Z.
- States: IDLE, WR_X, WR_Y, WR_Z, SETTLE.
- IDLE, sample_valid=1, STANDBY=0, (DEPTH - fifo_sample_num) >= 3: latch x/y/z on that edge; go to WR_X.
- IDLE, sample_valid=1, STANDBY=0, free space < 3: drop the entire set; FIFO_OVR<=1 next cycle; stay IDLE. Partial sets are never written.
- IDLE, STANDBY=1: sample_valid ignored; no OVR.
- WR_X, WR_Y, WR_Z: wr_en=1 for exactly one cycle each, consecutive. filter_fifo_data holds the formatted X, Y, Z entry respectively, registered.
- Latency: X entry on the write port 1 cycle after the accepting sample_valid edge; Z entry 3 cycles after.
- SETTLE: one idle cycle, wr_en=0, so fifo_sample_num reflects the Z write before the next space check. Then go to IDLE.
- sample_valid while busy (WR_X..SETTLE): set dropped; FIFO_OVR<=1; in-progress set continues unaffected.
- STANDBY rising mid-set: current set completes; no tearing.
- ovr_clr and a new overflow event in the same cycle: set wins, FIFO_OVR=1.
- Simultaneous FIFO reads by register_files only free space; never cause a drop.
- filter_fifo_data holds its last value when wr_en=0.
- Occupancy compare is unsigned, width ADDR_WIDTH+1. fifo_sample_num > DEPTH is illegal and treated as full (drop + OVR).

Optional Feature:
- Macro: FIFO_DROP_CNT_EN.
- Defined: adds output drop_cnt[7:0]. Increments by 1 on every dropped set (space or busy drop, not STANDBY ignore) and saturates at 8'hFF. Reset to 0. Cleared by ovr_clr; if a drop coincides with ovr_clr, drop_cnt=1.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset, then sample_valid with x=20'h12345, y=20'hABCDE, z=20'h00001 into an empty FIFO -> three consecutive wr_en pulses carrying 24'h123451, 24'hABCDE0, 24'h000010; busy high for 4 cycles; FIFO_OVR=0.
- Fill FIFO to 14 entries (no reads), pulse sample_valid -> no wr_en; FIFO_OVR=1 next cycle; occupancy stays 14. Pulse ovr_clr -> FIFO_OVR=0.
- sample_valid pulses two cycles apart -> first set written intact as 3 entries; second dropped; FIFO_OVR=1; with FIFO_DROP_CNT_EN, drop_cnt=1.
- STANDBY=1 and 5 sample_valid pulses -> no wr_en, FIFO_OVR=0. Raise STANDBY during WR_Y of an accepted set -> Z entry still written.
- rst_n low during WR_Y -> wr_en=0 and filter_fifo_data=0 immediately (async); FIFO holds only the X entry; after release the next set starts at X.
- 16 sets with concurrent reg_fifo_read_en draining -> no overflow. Every third entry has bit0=1, starting with the first. Drop-counter saturation: 300 drops -> drop_cnt=8'hFF.
